// File: rtl/word_red_iter_pkg.sv
// Shared definitions for the iterative word-serial Montgomery reducer.
package word_red_iter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRed,
        StDone
    } red_state_e;

    // Bit position of qH inside q = qH * 2^R + 1.
    function automatic int unsigned calc_r(input int unsigned q_len, input int unsigned tl_len);
        return q_len - tl_len;
    endfunction

    // Result width after removing w * n_iter low bits.
    function automatic int unsigned calc_tw(input int unsigned k, input int unsigned w,
                                            input int unsigned n_iter);
        return k - w * n_iter + 1;
    endfunction

    // One spare bit so acc + m never wraps.
    function automatic int unsigned calc_acc_w(input int unsigned k);
        return k + 1;
    endfunction

    function automatic bit params_ok(input int unsigned k, input int unsigned q_len,
                                     input int unsigned tl_len, input int unsigned w,
                                     input int unsigned n_iter);
        return (q_len > tl_len) && (w >= 1) && (w <= q_len - tl_len) && (n_iter >= 1) &&
               (k >= w * n_iter + q_len);
    endfunction

endpackage

// File: rtl/word_red_step.sv
// One reduction iteration: acc_next = ((acc + m) >> W) + ((m * qH) << (R - W)).
module word_red_step
    import word_red_iter_pkg::*;
#(
    parameter int unsigned ACC_W  = 129,
    parameter int unsigned TL_LEN = 26,
    parameter int unsigned W      = 19,
    parameter int unsigned R      = 38,
    parameter int unsigned MUL_FF = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ACC_W-1:0]  acc,
    input  logic [TL_LEN-1:0] qH,
    output logic [ACC_W-1:0]  acc_next
);

    localparam int unsigned PROD_W = W + TL_LEN;

    logic [W-1:0]      m_c;
    logic [PROD_W-1:0] prod_c;
    logic [W-1:0]      m_use;
    logic [PROD_W-1:0] prod_use;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  term;

    // m makes the low W bits of acc + m zero, so the shift below is exact.
    assign m_c    = ~acc[W-1:0] + W'(1);
    assign prod_c = {{TL_LEN{1'b0}}, m_c} * {{W{1'b0}}, qH};

    if (MUL_FF != 0) begin : g_mul_ff
        logic [W-1:0]      m_q;
        logic [PROD_W-1:0] prod_q;

        // Capture m and m*qH in phase 0; acc is held until phase 1 consumes them.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                m_q    <= '0;
                prod_q <= '0;
            end else if (load) begin
                m_q    <= m_c;
                prod_q <= prod_c;
            end
        end

        assign m_use    = m_q;
        assign prod_use = prod_q;
    end else begin : g_mul_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, load};
        assign m_use       = m_c;
        assign prod_use    = prod_c;
    end

    // Combine the exact division of acc + m with the m*qH contribution.
    always_comb begin
        sum      = acc + {{(ACC_W - W){1'b0}}, m_use};
        term     = {{(ACC_W - PROD_W){1'b0}}, prod_use} << (R - W);
        acc_next = (sum >> W) + term;
    end

endmodule

// File: rtl/word_red_iter.sv
// Iterative Montgomery reduction with valid/ready handshake and tag pass-through.
module word_red_iter
    import word_red_iter_pkg::*;
#(
    parameter int unsigned K      = 128,
    parameter int unsigned Q_LEN  = 64,
    parameter int unsigned TL_LEN = 26,
    parameter int unsigned W      = 19,
    parameter int unsigned N_ITER = 2,
    parameter int unsigned MUL_FF = 0,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [K-1:0]                        C,
    input  logic [TL_LEN-1:0]                   qH,
    input  logic [TAG_W-1:0]                    in_tag,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [calc_tw(K, W, N_ITER)-1:0]    T,
    output logic [TAG_W-1:0]                    out_tag
);

    localparam int unsigned R     = calc_r(Q_LEN, TL_LEN);
    localparam int unsigned TW    = calc_tw(K, W, N_ITER);
    localparam int unsigned ACC_W = calc_acc_w(K);
    localparam int unsigned CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    if (!params_ok(K, Q_LEN, TL_LEN, W, N_ITER)) begin : g_bad_params
        $error("word_red_iter: illegal parameter combination");
    end

    red_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [TL_LEN-1:0] qh_q, qh_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TW-1:0]     t_q, t_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              load;

    // Phase 0 of an iteration is the only time the optional product register loads.
    assign load = (state_q == StRed) && !phase_q;

    word_red_step #(
        .ACC_W  (ACC_W),
        .TL_LEN (TL_LEN),
        .W      (W),
        .R      (R),
        .MUL_FF (MUL_FF)
    ) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .acc      (acc_q),
        .qH       (qh_q),
        .acc_next (acc_next)
    );

    // Next-state logic: accept in IDLE, iterate in RED, hold result in DONE.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        qh_d      = qh_q;
        tag_d     = tag_q;
        t_d       = t_q;
        out_tag_d = out_tag_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = {1'b0, C};
                    qh_d    = qH;
                    tag_d   = in_tag;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = StRed;
                end
            end
            StRed: begin
                if ((MUL_FF != 0) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    acc_d   = acc_next;
                    phase_d = 1'b0;
                    if (cnt_q == CNT_W'(N_ITER - 1)) begin
                        state_d   = StDone;
                        t_d       = acc_next[TW-1:0];
                        out_tag_d = tag_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            qh_q      <= '0;
            tag_q     <= '0;
            t_q       <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            qh_q      <= qh_d;
            tag_q     <= tag_d;
            t_q       <= t_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign T         = t_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_word_red_iter.sv
// Directed and random checks of word_red_iter (default parameters, MUL_FF = 0 and 1).
module tb_word_red_iter;

    localparam int unsigned NRAND = 1000;
    localparam logic [127:0] KC  = 128'h82e2e662f728b4fa42485e3a0a5d2f34;
    localparam logic [25:0]  KQH = 26'h2000046;
    localparam logic [90:0]  KT  = 91'h20b8b9997c7ea16ab8e3941;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_valid1, out_ready, out_ready1;
    logic [127:0] C;
    logic [25:0]  qH;
    logic [3:0]   in_tag;
    logic         in_ready, in_ready1, out_valid, out_valid1;
    logic [90:0]  T, T1;
    logic [3:0]   out_tag, out_tag1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_red_iter #(.MUL_FF(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .qH        (qH),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .T         (T),
        .out_tag   (out_tag)
    );

    word_red_iter #(.MUL_FF(1)) dut_ff (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .C         (C),
        .qH        (qH),
        .in_tag    (in_tag),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .T         (T1),
        .out_tag   (out_tag1)
    );

    // Single-shot reference: (C + ((-C) mod 2^38) * q) >> 38.
    function automatic logic [90:0] golden(input logic [127:0] c, input logic [25:0] qh);
        logic [255:0] q, m, s;
        q = (256'(qh) << 38) + 256'd1;
        m = (256'd0 - 256'(c)) & ((256'd1 << 38) - 256'd1);
        s = (256'(c) + m * q) >> 38;
        return s[90:0];
    endfunction

    // Drive one transaction into dut (sel=0) or dut_ff (sel=1); lat = cycles to out_valid.
    task automatic send(input bit sel, input logic [127:0] c, input logic [25:0] qh,
                        input logic [3:0] tag, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(sel ? in_ready1 : in_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        C = c;
        qH = qh;
        in_tag = tag;
        if (sel) in_valid1 = 1'b1;
        else in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        lat = 0;
        while (!(sel ? out_valid1 : out_valid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (T !== 91'd0) begin n_fail++; $display("FAIL reset_T got %h want 0", T); end
        if (out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_ff got %b want 1", in_ready1); end
    endtask

    task automatic test_known();
        int lat;
        out_ready = 1'b0;
        send(1'b0, KC, KQH, 4'h5, lat);
        n_checks += 3;
        if (lat !== 2) begin n_fail++; $display("FAIL known_latency got %0d want 2", lat); end
        if (T !== KT) begin n_fail++; $display("FAIL known_T got %h want %h", T, KT); end
        if (out_tag !== 4'h5) begin n_fail++; $display("FAIL known_tag got %h want 5", out_tag); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL known_release_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL known_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_known_ff();
        int lat;
        out_ready1 = 1'b0;
        send(1'b1, KC, KQH, 4'h5, lat);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL ff_latency got %0d want 4", lat); end
        if (T1 !== KT) begin n_fail++; $display("FAIL ff_T got %h want %h", T1, KT); end
        if (out_tag1 !== 4'h5) begin n_fail++; $display("FAIL ff_tag got %h want 5", out_tag1); end
        out_ready1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL ff_release_ready got %b want 1", in_ready1); end
    endtask

    task automatic test_small_values();
        int lat;
        logic [255:0] q, r;
        out_ready = 1'b0;
        send(1'b0, 128'd0, 26'h3ffffff, 4'h0, lat);
        n_checks += 2;
        if (lat !== 2) begin n_fail++; $display("FAIL zero_latency got %0d want 2", lat); end
        if (T !== 91'd0) begin n_fail++; $display("FAIL zero_T got %h want 0", T); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send(1'b0, 128'd1, KQH, 4'h1, lat);
        q = (256'(KQH) << 38) + 256'd1;
        r = (256'(T) << 38) % q;
        n_checks += 2;
        if (T !== golden(128'd1, KQH)) begin
            n_fail++; $display("FAIL one_T got %h want %h", T, golden(128'd1, KQH));
        end
        if (r !== 256'd1) begin n_fail++; $display("FAIL one_congruence got %h want 1", r); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        send(1'b0, KC, KQH, 4'h9, lat);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            C = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_tag = 4'(k);
            in_valid = (k % 2 == 0);
            @(negedge clk);
            n_checks += 4;
            if (T !== KT) begin n_fail++; $display("FAIL bp_T_stable got %h want %h", T, KT); end
            if (out_tag !== 4'h9) begin n_fail++; $display("FAIL bp_tag_stable got %h want 9", out_tag); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_extra_txn got %0d valid cycles want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b0;
        @(negedge clk);
        C = KC;
        qH = KQH;
        in_tag = 4'h3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        if (T !== 91'd0) begin n_fail++; $display("FAIL rmid_T got %h want 0", T); end
        if (out_tag !== 4'd0) begin n_fail++; $display("FAIL rmid_tag got %h want 0", out_tag); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after_valid got %b want 0", out_valid); end
        send(1'b0, KC, KQH, 4'h6, lat);
        n_checks += 3;
        if (lat !== 2) begin n_fail++; $display("FAIL rmid_next_latency got %0d want 2", lat); end
        if (T !== KT) begin n_fail++; $display("FAIL rmid_next_T got %h want %h", T, KT); end
        if (out_tag !== 4'h6) begin n_fail++; $display("FAIL rmid_next_tag got %h want 6", out_tag); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [90:0]  exp_t[$];
        logic [3:0]   exp_tag[$];
        logic [127:0] cur_c;
        logic [25:0]  cur_qh;
        logic [31:0]  r32;
        logic [90:0]  et;
        logic [3:0]   etag;
        int sent, dguard, last_acc, rcv, mguard;
        bit have_last;
        sent = 0;
        rcv = 0;
        have_last = 1'b0;
        last_acc = 0;
        cur_c = {$urandom(), $urandom(), $urandom(), $urandom()};
        r32 = $urandom();
        cur_qh = r32[25:0];
        fork
            begin
                dguard = 0;
                while (sent < NRAND && dguard < 60000) begin
                    @(negedge clk);
                    dguard++;
                    C = cur_c;
                    qH = cur_qh;
                    in_tag = 4'(sent);
                    in_valid = 1'b1;
                    if (in_ready) begin
                        exp_t.push_back(golden(cur_c, cur_qh));
                        exp_tag.push_back(4'(sent));
                        if (have_last) begin
                            n_checks++;
                            if (cyc - last_acc < 4) begin
                                n_fail++;
                                $display("FAIL rand_spacing got %0d want >= 4", cyc - last_acc);
                            end
                        end
                        have_last = 1'b1;
                        last_acc = cyc;
                        sent++;
                        cur_c = {$urandom(), $urandom(), $urandom(), $urandom()};
                        r32 = $urandom();
                        cur_qh = r32[25:0];
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                mguard = 0;
                while (rcv < NRAND && mguard < 60000) begin
                    @(negedge clk);
                    mguard++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (exp_t.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_unexpected got T=%h want no result", T);
                        end else begin
                            et = exp_t.pop_front();
                            etag = exp_tag.pop_front();
                            n_checks++;
                            if (T !== et) begin
                                n_fail++; $display("FAIL rand_T #%0d got %h want %h", rcv, T, et);
                            end
                            if (out_tag !== etag) begin
                                n_fail++; $display("FAIL rand_tag #%0d got %h want %h", rcv, out_tag, etag);
                            end
                        end
                        rcv++;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        n_checks++;
        if (rcv !== int'(NRAND)) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", rcv, NRAND);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        out_ready = 1'b0;
        out_ready1 = 1'b0;
        C = '0;
        qH = '0;
        in_tag = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_known();
        test_known_ff();
        test_small_values();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
